dff_async_clr_pre: RTL and testbench
====================================

Name: dff_async_clr_pre

Overview:
- Generic D flip-flop with asynchronous active-high clear (CLR) and preset (PRE), plus a global asynchronous active-low reset (RST).
- Drop-in equivalent of the vendor FDCP primitive, widened by a parameter.
- Used throughout the board logic as:
  - an edge-captured request flag (e.g. refresh request: D=0, clocked by a strobe, set by PRE);
  - a pure async set/reset latch (CLK tied 0, D tied 0; Q cleared by CLR, set by PRE), e.g. VALID/WTERM handshake latches.

Parameters:
- WIDTH, 1, number of independent flop bits.
- INIT, {WIDTH{1'b0}}, value loaded by RST; also the power-up/simulation initial value of Q.

Ports:
- CLK input 1: clock, rising-edge; may be tied constant (pure latch use).
- RST input 1: asynchronous active-low reset; Q <= INIT while low.
- D input WIDTH: data captured on rising CLK.
- CE input 1: clock enable, active-high; tie 1 for plain FDCP behaviour.
- CLR input WIDTH: per-bit asynchronous clear, active-high, forces bit to 0.
- PRE input WIDTH: per-bit asynchronous preset, active-high, forces bit to 1.
- Q output WIDTH: registered state.

Behaviour:
- Per bit i, priority is highest first: RST low > CLR[i] high > PRE[i] high > rising CLK with CE=1.
  - RST low: Q <= INIT immediately, independent of CLK, for as long as RST stays low.
  - CLR[i] high with RST high: Q[i] <= 0 immediately and held.
  - PRE[i] high with CLR[i] low and RST high: Q[i] <= 1 immediately and held.
  - Otherwise, on rising CLK with CE=1: Q[i] <= D[i]. With CE=0, Q holds.
- Simultaneous CLR[i] and PRE[i] high: Q[i]=0 (clear wins).
- Release of an async input: Q keeps the forced value until the next qualifying CLK edge or the next async assertion. No glitch, no reversion.
- Async assertion coinciding with a CLK edge: the async value wins.
- CLK tied constant: the block is a set/reset latch; Q changes only via RST/CLR/PRE.
- Initial value of Q at time 0 (simulation and FPGA GSR) is INIT.
- Bits are fully independent; no cross-bit coupling.
- Zero combinational path from D to Q.
- Q changes from the async inputs within one gate delay, with no clock needed.

Decomposition:
- Shared package: none required. Optionally define a localparam table of priority encodings for documentation/assertions only.
- Natural sub-module: dff_async_clr_pre_bit, a single-bit cell with scalar CLR/PRE/D/Q and shared CLK/CE/RST, INIT_BIT parameter. The top level generate-replicates it WIDTH times.
- Include SVA-style checks in the verification build only:
  - after any CLR edge, Q==0;
  - PRE without CLR gives Q==1.

Test Plan:
- Reset: WIDTH=1, INIT=1, RST=0 with CLK toggling and D=0 → Q=1 throughout. Release RST, then rising CLK with D=0, CE=1 → Q=0.
- Async latch mode: CLK=0, D=0. Pulse PRE=1 for 5 ns → Q=1 within the pulse and holds after release. Pulse CLR=1 → Q=0 and holds.
- Priority: CLR=1 and PRE=1 together → Q=0. Drop CLR while PRE stays 1 → Q=1. With RST=0 plus PRE=1 → Q=INIT.
- Request-flag use: D=0. PRE pulse sets Q=1. Rising CLK edge with CE=1 → Q=0. Repeat with CE=0 → Q stays 1.
- Edge/async race: assert PRE in the same timestep as a rising CLK with D=0 → Q=1. Assert CLR with D=1 at a CLK edge → Q=0.
- Width: WIDTH=4, INIT=4'b1010. CLR=4'b0001, PRE=4'b0100 after reset → Q=4'b1110. Then clock D=4'b0011 with CLR/PRE low → Q=4'b0011.

Source files
------------

// File: rtl/dff_async_clr_pre_pkg.sv
// Shared definitions for the async clear/preset flop: the priority order of
// state sources and the mapping from RST/CLR/PRE to the cell's async pins.
package dff_async_clr_pre_pkg;

    typedef enum logic [1:0] {
        SRC_RST = 2'd0,
        SRC_CLR = 2'd1,
        SRC_PRE = 2'd2,
        SRC_CLK = 2'd3
    } q_src_e;

    // Returns {async_set, async_clr}; the two are never high together.
    // Folding RST/INIT into plain set/clear lines means that releasing a
    // higher-priority input raises the surviving one, so Q updates right away.
    function automatic logic [1:0] async_ctl(input logic rst, input logic clr,
                                             input logic pre, input logic init);
        logic set_l;
        logic clr_l;
        set_l = rst ? (!clr && pre) : init;
        clr_l = rst ? clr : !init;
        return {set_l, clr_l};
    endfunction

endpackage

// File: rtl/dff_async_clr_pre_bit.sv
// Single-bit flop with async clear and async preset.
// Priority: RST low > CLR > PRE > CLK with CE.
module dff_async_clr_pre_bit
    import dff_async_clr_pre_pkg::*;
#(
    parameter logic INIT_BIT = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic CE,
    input  logic D,
    input  logic CLR,
    input  logic PRE,
    output logic Q
);

    logic async_set;
    logic async_clr;

    assign {async_set, async_clr} = async_ctl(RST, CLR, PRE, INIT_BIT);

    always_ff @(posedge CLK or posedge async_clr or posedge async_set) begin
        if (async_clr)
            Q <= 1'b0;
        else if (async_set)
            Q <= 1'b1;
        else if (CE)
            Q <= D;
    end

endmodule

// File: rtl/dff_async_clr_pre.sv
// WIDTH independent flops with per-bit async clear/preset and a shared
// async active-low reset that loads INIT.
module dff_async_clr_pre
    import dff_async_clr_pre_pkg::*;
#(
    parameter int               WIDTH = 1,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] D,
    input  logic             CE,
    input  logic [WIDTH-1:0] CLR,
    input  logic [WIDTH-1:0] PRE,
    output logic [WIDTH-1:0] Q
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_async_clr_pre_bit #(
            .INIT_BIT (INIT[i])
        ) u_bit (
            .CLK (CLK),
            .RST (RST),
            .CE  (CE),
            .D   (D[i]),
            .CLR (CLR[i]),
            .PRE (PRE[i]),
            .Q   (Q[i])
        );

`ifndef SYNTHESIS
        // A clear that has been held across a clock edge always leaves 0.
        a_clr_wins : assert property (@(posedge CLK) (RST && CLR[i]) |-> !Q[i]);
        a_pre_sets : assert property (@(posedge CLK) (RST && PRE[i] && !CLR[i]) |-> Q[i]);
`endif
    end

endmodule

// File: tb/tb_dff_async_clr_pre.sv
// Scoreboard bench for dff_async_clr_pre: a 1-bit INIT=1 instance and a
// 4-bit INIT=1010 instance, exercised in latch, flag and race usage.
module tb_dff_async_clr_pre;

    typedef struct {
        string      tag;
        bit         wide;
        logic [3:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    logic       a_clk, a_rst, a_d, a_ce, a_clr, a_pre, a_q;
    logic       b_clk, b_rst, b_ce;
    logic [3:0] b_d, b_clr, b_pre, b_q;

    dff_async_clr_pre #(.WIDTH(1), .INIT(1'b1)) u_a (
        .CLK(a_clk), .RST(a_rst), .D(a_d), .CE(a_ce),
        .CLR(a_clr), .PRE(a_pre), .Q(a_q)
    );

    dff_async_clr_pre #(.WIDTH(4), .INIT(4'b1010)) u_b (
        .CLK(b_clk), .RST(b_rst), .D(b_d), .CE(b_ce),
        .CLR(b_clr), .PRE(b_pre), .Q(b_q)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %b, want %b", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input bit wide, input logic [3:0] exp);
        exp_t e;
        e.tag  = tag;
        e.wide = wide;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    // Let async changes settle, then retire the oldest expectation.
    task automatic pop_chk();
        exp_t e;
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 4'd1, 4'd0);
            return;
        end
        e = sb.pop_front();
        if (e.wide) chk(e.tag, b_q, e.exp);
        else        chk(e.tag, {3'b000, a_q}, e.exp);
    endtask

    task automatic a_edge();
        #2 a_clk = 1'b1;
        #2 a_clk = 1'b0;
    endtask

    task automatic b_edge();
        #2 b_clk = 1'b1;
        #2 b_clk = 1'b0;
    endtask

    initial begin
        a_clk = 0; a_rst = 0; a_d = 0; a_ce = 1; a_clr = 0; a_pre = 0;
        b_clk = 0; b_rst = 0; b_d = '0; b_ce = 1; b_clr = '0; b_pre = '0;

        // Reset holds INIT despite clocking D=0
        push("a_rst", 0, 4'd1); pop_chk();
        for (int i = 0; i < 3; i++) begin
            a_edge();
            push("a_rst_clk", 0, 4'd1); pop_chk();
        end
        a_rst = 1;
        push("a_rst_rel", 0, 4'd1); pop_chk();
        a_edge();
        push("a_first_clk", 0, 4'd0); pop_chk();

        // Async latch mode, CLK idle
        a_pre = 1;
        push("a_pre_in", 0, 4'd1); pop_chk();
        #4 a_pre = 0;
        push("a_pre_hold", 0, 4'd1); pop_chk();
        a_clr = 1;
        push("a_clr_in", 0, 4'd0); pop_chk();
        #4 a_clr = 0;
        push("a_clr_hold", 0, 4'd0); pop_chk();

        // Priority
        a_clr = 1; a_pre = 1;
        push("a_clr_pre", 0, 4'd0); pop_chk();
        a_clr = 0;
        push("a_clr_drop", 0, 4'd1); pop_chk();
        a_pre = 0; a_clr = 1;
        push("a_clr_q0", 0, 4'd0); pop_chk();
        a_rst = 0;
        push("a_rst_ovr_clr", 0, 4'd1); pop_chk();
        a_rst = 1;
        push("a_rst_rel_clr", 0, 4'd0); pop_chk();
        a_clr = 0;

        // Request flag: PRE sets, clock with D=0 clears, CE=0 holds
        a_d = 0; a_ce = 1;
        a_pre = 1; #2 a_pre = 0;
        push("flag_set", 0, 4'd1); pop_chk();
        a_edge();
        push("flag_clk", 0, 4'd0); pop_chk();
        a_pre = 1; #2 a_pre = 0;
        a_ce = 0;
        a_edge();
        push("flag_ce0", 0, 4'd1); pop_chk();

        // Async assertion in the same timestep as a rising edge
        a_ce = 1;
        a_edge();
        push("race_pre_pre", 0, 4'd0); pop_chk();
        #2 a_pre = 1; a_clk = 1;
        push("race_pre", 0, 4'd1); pop_chk();
        #2 a_pre = 0; a_clk = 0;
        a_d = 1;
        #2 a_clr = 1; a_clk = 1;
        push("race_clr", 0, 4'd0); pop_chk();
        #2 a_clr = 0; a_clk = 0;
        push("race_clr_hold", 0, 4'd0); pop_chk();
        a_edge();
        push("a_clk_d1", 0, 4'd1); pop_chk();

        // Width and per-bit independence
        push("b_rst", 1, 4'b1010); pop_chk();
        b_rst = 1;
        push("b_rst_rel", 1, 4'b1010); pop_chk();
        b_clr = 4'b0001; b_pre = 4'b0100;
        push("b_clr_pre", 1, 4'b1110); pop_chk();
        b_clr = '0; b_pre = '0;
        push("b_release", 1, 4'b1110); pop_chk();
        b_d = 4'b0011;
        b_edge();
        push("b_clk_d", 1, 4'b0011); pop_chk();
        b_ce = 0; b_d = 4'b1100;
        b_edge();
        push("b_ce0", 1, 4'b0011); pop_chk();
        b_rst = 0; b_pre = 4'b1111;
        push("b_rst_pre", 1, 4'b1010); pop_chk();
        b_rst = 1;
        push("b_rst_rel_pre", 1, 4'b1111); pop_chk();
        b_pre = '0; b_clr = 4'b0110;
        push("b_clr_mid", 1, 4'b1001); pop_chk();
        b_clr = 4'b1111; b_pre = 4'b1111;
        push("b_clr_pre_all", 1, 4'b0000); pop_chk();
        b_clr = '0;
        push("b_clr_drop", 1, 4'b1111); pop_chk();
        b_pre = '0;

        if (sb.size() != 0) chk("sb_leftover", 4'(sb.size()), 4'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
